shift_unit_iter: RTL and testbench
==================================

Name: shift_unit_iter

Overview:
- Parametrised, multi-cycle barrel shifter for the ALU datapath; successor to the fixed-distance shift stages.
- Applies one power-of-two stage per cycle: stage k shifts by 2^k when shamt bit k is set.
- Supports SLL, SRL, SRA and ROR, with a valid/ready handshake on both sides.
- Trades latency for area and timing versus the flat five-stage combinational shifter.

Parameters:
- WIDTH, 32, operand width in bits; must be a power of two and at least 2.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift distance; taken modulo WIDTH by construction
- in_op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n = 0 at a clock edge):
  - state goes to IDLE; stage index goes to 0.
  - in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
  - Reset mid-operation discards the in-flight request; no output is produced for it.
- States:
  - IDLE: in_ready = 1. On in_valid, latch data, shamt and op, clear stage index k to 0, go to SHIFT.
  - SHIFT: each edge applies stage k to the held data if shamt[k] = 1, then increments k. Leaves when k = SHAMT_W-1 has been processed.
  - DONE: out_valid = 1 and out_data is held stable. On out_ready, go to IDLE.
- Only in_ready = (state == IDLE); requests in other states are ignored.
- Stage k transforms, with s = 2^k:
  - SLL: shift left by s, zero fill.
  - SRL: shift right by s, zero fill.
  - SRA: shift right by s, filling with the current MSB. The MSB is invariant under SRA, so this equals the original sign bit.
  - ROR: rotate right by s.
- Latency with the macro off:
  - Accept at edge T; stages applied at edges T+1 through T+SHAMT_W.
  - out_valid is high from edge T+SHAMT_W; default build gives 5 shift cycles.
  - Latency is fixed regardless of shamt.
- Throughput: no overlap. The next accept happens no earlier than the edge after the out_ready handshake, because DONE→IDLE takes one edge.
- Back-pressure: with out_ready held low, the unit stays in DONE indefinitely with out_data unchanged.
- shamt = 0: out_data equals in_data after full latency, for every op.
- in_data, in_shamt and in_op may change freely after acceptance; they are not sampled again.

Optional Feature:
- Macro: SHIFT_UNIT_EARLY_EXIT_EN.
- Defined:
  - shamt = 0 at accept goes directly to DONE at edge T, with data latched unchanged (1-cycle latency).
  - Otherwise, after processing stage k, go to DONE if shamt[SHAMT_W-1:k+1] == 0.
  - Latency is therefore (index of the highest set shamt bit) + 1 edges after accept.
- Undefined: fixed SHAMT_W-cycle latency as above.
- Results are identical in both builds; only timing differs.

Test Plan:
- Reset check: hold reset_n = 0 for 2 edges, then release → in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
- SRA sign fill: in_data = 0x80000000, shamt = 8, op = SRA → out_data = 0xFF800000 with out_valid at edge T+5. With shamt = 31 → 0xFFFFFFFF.
- Mixed ops on in_data = 0x12345678, shamt = 4:
  - SLL → 0x23456780
  - SRL → 0x01234567
  - ROR → 0x81234567
  - SRA on 0xF0000000 → 0xFF000000
- Back-pressure: out_ready held low 10 cycles after result → out_valid stays 1, out_data stable, in_ready = 0, and a new in_valid is not accepted. Raising out_ready gives IDLE next edge.
- Reset mid-SHIFT: assert reset_n = 0 at edge T+2 → IDLE, out_valid never rises for that request. A new request then completes normally.
- SHIFT_UNIT_EARLY_EXIT_EN defined:
  - shamt = 0 → out_valid at edge T.
  - shamt = 3 → out_valid at edge T+2.
  - shamt = 16 → out_valid at edge T+5.
  - Results match the macro-off build.

Source files
------------

// File: rtl/shift_unit_iter.sv
// shift_unit_iter
// Multi-cycle barrel shifter: one power-of-two stage per clock. Stage k
// shifts the held operand by 2^k when bit k of the latched shift amount
// is set. Supports SLL, SRL, SRA and ROR behind valid/ready handshakes.
//
// Optional build macro: SHIFT_UNIT_EARLY_EXIT_EN
//   defined   -> leave SHIFT as soon as no higher shamt bits remain
//                (shamt = 0 completes directly at the accept edge)
//   undefined -> fixed SHAMT_W shift cycles for every request
//
// Ports:
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   request present
//   in_ready   unit idle and able to accept a request
//   in_data    operand (WIDTH bits)
//   in_shamt   shift distance (SHAMT_W bits, modulo WIDTH by construction)
//   in_op      00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR
//   out_valid  result available (held until out_ready)
//   out_ready  consumer takes result
//   out_data   result (WIDTH bits)
//   busy       high while shifting or holding a result
module shift_unit_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    localparam logic [SHAMT_W-1:0] LAST_K = SHAMT_W'(SHAMT_W - 1);

    state_e             state, state_nxt;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] shamt_q;
    op_e                op_q;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   stage_out;
    logic               last_stage;

    // One fixed-distance transform; s is always < WIDTH so WIDTH - s > 0.
    function automatic logic [WIDTH-1:0] apply_stage(
        input logic [WIDTH-1:0] d,
        input op_e              op,
        input int unsigned      s
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        fill = {WIDTH{d[WIDTH-1]}};
        case (op)
            OP_SLL:  r = d << s;
            OP_SRL:  r = d >> s;
            OP_SRA:  r = (d >> s) | (fill << (WIDTH - s));
            default: r = (d >> s) | (d << (WIDTH - s));
        endcase
        return r;
    endfunction

    // Select the stage for the current index; bypass when that shamt bit is clear.
    always_comb begin
        stage_out = data_q;
        for (int unsigned i = 0; i < SHAMT_W; i++) begin
            if (k == SHAMT_W'(i) && shamt_q[i]) begin
                stage_out = apply_stage(data_q, op_q, 32'd1 << i);
            end
        end
    end

`ifdef SHIFT_UNIT_EARLY_EXIT_EN
    // Done once no set shamt bits remain above the stage just processed.
    assign last_stage = ((shamt_q >> (k + 1'b1)) == '0);
`else
    assign last_stage = (k == LAST_K);
`endif

    // State register and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= OP_SLL;
            k       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        shamt_q <= in_shamt;
                        op_q    <= op_e'(in_op);
                        k       <= '0;
                    end
                end
                SHIFT: begin
                    data_q <= stage_out;
                    k      <= k + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SHIFT_UNIT_EARLY_EXIT_EN
                    state_nxt = (in_shamt == '0) ? DONE : SHIFT;
`else
                    state_nxt = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (last_stage) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_data  = data_q;
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
module tb_shift_unit_iter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int total;
    int bad;

    shift_unit_iter #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-distance reference: the unit must equal a single shift by shamt.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        logic signed [31:0] sd;
        logic [63:0]        dd;
        logic [31:0]        r;
        sd = d;
        dd = {d, d} >> s;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = sd >>> s;
            default: r = dd[31:0];
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [4:0] s);
`ifdef SHIFT_UNIT_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < 5; i++) if (s[i]) h = i + 1;
        return h;
`else
        return (s == s) ? 5 : 5;
`endif
    endfunction

    task automatic start_req(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = 5'($urandom);
        in_op    = 2'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, " ready after take"}, {31'd0, in_ready}, 32'd1);
        check({tag, " valid after take"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_req(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                           input logic [31:0] exp, input string tag);
        int lat;
        check({tag, " idle ready"}, {31'd0, in_ready}, 32'd1);
        start_req(d, s, op);
        wait_valid(lat);
        check({tag, " latency"}, lat, exp_lat(s));
        check({tag, " data"}, out_data, exp);
        handshake(tag);
    endtask

    initial begin
        vec_t vecs[16];
        logic [31:0] d, e, held;
        logic [4:0]  s;
        logic [1:0]  op;
        int          lat;
        bit          seen;

        total = 0;
        bad   = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b0;

        vecs[0]  = '{32'h8000_0000, 5'd8,  2'b10, 32'hFF80_0000};
        vecs[1]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
        vecs[2]  = '{32'h1234_5678, 5'd4,  2'b00, 32'h2345_6780};
        vecs[3]  = '{32'h1234_5678, 5'd4,  2'b01, 32'h0123_4567};
        vecs[4]  = '{32'h1234_5678, 5'd4,  2'b11, 32'h8123_4567};
        vecs[5]  = '{32'hF000_0000, 5'd4,  2'b10, 32'hFF00_0000};
        vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF};
        vecs[7]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF};
        vecs[8]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF};
        vecs[9]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF};
        vecs[10] = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000};
        vecs[11] = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000};
        vecs[12] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
        vecs[13] = '{32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000};
        vecs[14] = '{32'h1234_5678, 5'd16, 2'b11, 32'h5678_1234};
        vecs[15] = '{32'h0000_00FF, 5'd21, 2'b00, 32'h1FE0_0000};

        // Reset held for two edges.
        @(posedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);

        // Table vectors.
        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i].d, vecs[i].s, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Busy during shift, then back-pressure.
        start_req(32'h8000_0000, 5'd8, 2'b10);
        if (exp_lat(5'd8) > 0) check("busy in shift", {31'd0, busy}, 32'd1);
        wait_valid(lat);
        check("bp latency", lat, exp_lat(5'd8));
        held = 32'hFF80_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = 5'd1;
            in_op    = 2'b00;
            @(posedge clock);
            #1;
            check($sformatf("bp valid c%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp data c%0d", c), out_data, held);
            check($sformatf("bp in_ready c%0d", c), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        handshake("bp");
        check("bp idle busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        check("bp no stale accept", {31'd0, busy}, 32'd0);

        // Reset mid-SHIFT at edge T+2.
        start_req(32'h1234_5678, 5'd31, 2'b01);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst out_data", out_data, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst no output", {31'd0, seen}, 32'd0);
        run_req(32'hF000_0000, 5'd4, 2'b10, 32'hFF00_0000, "after midrst");

        // Randomised against the whole-distance model.
        for (int n = 0; n < 150; n++) begin
            d  = $urandom;
            s  = 5'($urandom);
            op = 2'($urandom);
            e  = model(d, s, op);
            run_req(d, s, op, e, $sformatf("rnd%0d op%0d s%0d", n, op, s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
